uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter; pairs with the existing UART receiver on the same serial link.
Accepts a parallel data word over a valid/ready handshake and serializes it LSB-first on tx_o.
Frame format: 1 start bit (low), data_bits_p data bits, optional parity bit, stop_bits_p stop bits (high).
Sits between the host-side logic (e.g. debug/console bridge) and the board UART TX pin.

Parameters:
clk_per_bit_p, 10416, clock cycles per serial bit (100 MHz / 9600 baud); must be >= 2
data_bits_p, 8, data bits per frame, 5..9
parity_bits_p, 0, 0 = no parity, 1 = parity bit after data
parity_odd_p, 0, 0 = even parity, 1 = odd parity; ignored when parity_bits_p = 0
stop_bits_p, 1, stop bits per frame, 1 or 2

Ports:
clk_i  input  1  clock
reset_n_i  input  1  reset; one clock; reset is asynchronous and active-low
tx_v_i  input  1  data word valid
tx_i  input  data_bits_p  data word, LSB transmitted first
tx_ready_o  output  1  block can accept a word this cycle
tx_o  output  1  serial line, idle high, registered
tx_done_o  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async assert, sync release): state e_idle; tx_o = 1; tx_ready_o = 1; tx_done_o = 0; counters and shift register cleared.
- Reset asserted mid-frame: frame is abandoned. tx_o returns to 1 immediately. No tx_done_o pulse.
- Handshake: a transfer occurs on a cycle where tx_v_i & tx_ready_o. tx_i is captured into the shift register that cycle. tx_ready_o = 1 only in e_idle. tx_v_i while not ready is ignored; it is not queued.
- States: e_idle -> e_start -> e_data -> (e_parity if parity_bits_p) -> e_stop -> e_idle.
- e_idle: tx_o = 1. Leave on transfer.
- Every non-idle state holds tx_o for exactly clk_per_bit_p cycles, timed by a bit counter 0..clk_per_bit_p-1. Counter width is clog2(clk_per_bit_p+1). The counter advances the state at clk_per_bit_p-1.
- e_start: tx_o = 0.
- e_data: tx_o = current shift-register bit 0. Shift right at the end of each bit. Bit index counts 0..data_bits_p-1.
- e_parity: tx_o = XOR of the captured word; inverted if parity_odd_p = 1. The parity is computed at capture and stored.
- e_stop: tx_o = 1 for stop_bits_p bit times. tx_done_o pulses on the final cycle of the last stop bit; e_idle is entered the next cycle.
- Latency: tx_o falls on the cycle after the transfer. Frame length is (1 + data_bits_p + parity_bits_p + stop_bits_p) * clk_per_bit_p cycles. tx_ready_o rises on the cycle after tx_done_o. Back-to-back frames therefore have a 1-cycle minimum idle-high gap.
- tx_o is driven straight from a flop (no combinational glitches). It never changes except at bit boundaries.
- Illegal state encoding: return to e_idle with tx_o = 1.

Optional Feature:
Macro UART_TX_CTS_EN.
- Defined: adds input cts_n_i (active-low clear-to-send). cts_n_i is synchronized through 2 flops, reset to 1 (not clear). tx_ready_o = e_idle & synchronized cts low. CTS deasserting mid-frame does not stop the current frame.
- Not defined: port absent; tx_ready_o = e_idle.

Decomposition:
- Shared package uart_pkg:
  - state enum for this block (uart_tx_state_e)
  - parity helper function (word, odd) -> parity bit, also usable by the receiver
  - a localparam for the default 100 MHz / 9600 clk_per_bit value
- One natural sub-module: uart_bit_timer. It provides the cycle counter with clear/enable and a last-cycle strobe. The receiver can reuse it later.

Test Plan:
- clk_per_bit_p=4, 8N1, send 0x55 -> tx_o low at accept+1. Then 4-cycle bits 1,0,1,0,1,0,1,0, stop high. tx_done_o at accept+40. tx_ready_o at accept+41.
- parity_bits_p=1 even, send 0x07 -> parity bit 1. Odd parity, send 0x07 -> parity bit 0. Even parity, send 0x55 -> parity bit 0.
- stop_bits_p=2, data_bits_p=5, send 0x1F -> 5 ones followed by 8 high cycles. tx_done_o at accept+32.
- Hold tx_v_i high with 0xA5 then 0x3C -> exactly two frames, with a 1-cycle idle gap. Extra valid cycles during busy are not sent. A loopback into the receiver yields 0xA5, 0x3C with no frame error.
- Assert reset_n_i low mid-data-bit -> tx_o = 1 in the same cycle, tx_ready_o = 1 after release, no tx_done_o.
- With UART_TX_CTS_EN: cts_n_i=1 with valid held -> no transfer. Drop cts_n_i -> accept occurs 2-3 cycles later. Raise cts_n_i mid-frame -> frame completes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity helper and default
// bit timing for a 100 MHz clock at 9600 baud.
package uart_pkg;

  localparam int unsigned ClkPerBitDefault = 10416;
  localparam int unsigned MaxDataBits      = 9;

  typedef enum logic [2:0] {
    e_idle   = 3'd0,
    e_start  = 3'd1,
    e_data   = 3'd2,
    e_parity = 3'd3,
    e_stop   = 3'd4
  } uart_tx_state_e;

  // Narrower words must be zero-extended by the caller; the extra zeros do not
  // change the XOR.
  function automatic logic uart_parity(input logic [MaxDataBits-1:0] i_word,
                                       input logic                   i_odd);
    return (^i_word) ^ i_odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..clk_per_bit_p-1 while enabled and strobes o_last
// on the final cycle of each bit. Shared by the UART transmitter and receiver.
module uart_bit_timer #(
  parameter int unsigned clk_per_bit_p = 10416
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last
);

  localparam int unsigned        CountW    = $clog2(clk_per_bit_p + 1);
  localparam logic [CountW-1:0]  LastCount = CountW'(clk_per_bit_p - 1);

  logic [CountW-1:0] r_count;

  assign o_last = i_enable && (r_count == LastCount);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, LSB-first framed serial out on tx_o.
// Optional macro UART_TX_CTS_EN adds an active-low clear-to-send input.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_per_bit_p = ClkPerBitDefault,
  parameter int unsigned data_bits_p   = 8,
  parameter int unsigned parity_bits_p = 0,
  parameter int unsigned parity_odd_p  = 0,
  parameter int unsigned stop_bits_p   = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   tx_v_i,
  input  logic [data_bits_p-1:0] tx_i,
  output logic                   tx_ready_o,
  output logic                   tx_o,
  output logic                   tx_done_o
`ifdef UART_TX_CTS_EN
  ,
  input  logic                   cts_n_i
`endif
);

  localparam int unsigned      IdxW        = $clog2(data_bits_p);
  localparam logic [IdxW-1:0]  LastDataIdx = IdxW'(data_bits_p - 1);
  localparam logic             LastStopIdx = (stop_bits_p == 2);
  localparam logic             ParityEn    = (parity_bits_p != 0);
  localparam logic             ParityOdd   = (parity_odd_p != 0);

  uart_tx_state_e         r_state;
  uart_tx_state_e         w_state_next;
  logic [data_bits_p-1:0] r_shift;
  logic [IdxW-1:0]        r_bit_idx;
  logic                   r_stop_idx;
  logic                   r_parity;
  logic                   r_tx;
  logic                   w_tx_next;
  logic                   w_cts_ok;
  logic                   w_idle;
  logic                   w_accept;
  logic                   w_bit_last;

`ifdef UART_TX_CTS_EN
  logic [1:0] r_cts_sync;

  // Resets to "not clear" so nothing is accepted until CTS is seen low twice.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cts_sync <= 2'b11;
    end else begin
      r_cts_sync <= {r_cts_sync[0], cts_n_i};
    end
  end

  assign w_cts_ok = ~r_cts_sync[1];
`else
  assign w_cts_ok = 1'b1;
`endif

  assign w_idle     = (r_state == e_idle);
  assign tx_ready_o = w_idle & w_cts_ok;
  assign w_accept   = tx_v_i & tx_ready_o;
  assign tx_o       = r_tx;
  assign tx_done_o  = (r_state == e_stop) && w_bit_last && (r_stop_idx == LastStopIdx);

  uart_bit_timer #(
    .clk_per_bit_p(clk_per_bit_p)
  ) u_bit_timer (
    .i_clk     (clk_i),
    .i_reset_n (reset_n_i),
    .i_clear   (w_idle),
    .i_enable  (!w_idle),
    .o_last    (w_bit_last)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // w_tx_next is the line level for the coming cycle, so tx_o is a pure flop output.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    case (r_state)
      e_idle: begin
        w_tx_next = 1'b1;
        if (w_accept) begin
          w_state_next = e_start;
          w_tx_next    = 1'b0;
        end
      end
      e_start: begin
        if (w_bit_last) begin
          w_state_next = e_data;
          w_tx_next    = r_shift[0];
        end
      end
      e_data: begin
        if (w_bit_last) begin
          if (r_bit_idx != LastDataIdx) begin
            w_tx_next = r_shift[1];
          end else if (ParityEn) begin
            w_state_next = e_parity;
            w_tx_next    = r_parity;
          end else begin
            w_state_next = e_stop;
            w_tx_next    = 1'b1;
          end
        end
      end
      e_parity: begin
        if (w_bit_last) begin
          w_state_next = e_stop;
          w_tx_next    = 1'b1;
        end
      end
      e_stop: begin
        w_tx_next = 1'b1;
        if (w_bit_last && (r_stop_idx == LastStopIdx)) begin
          w_state_next = e_idle;
        end
      end
      default: begin
        w_state_next = e_idle;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      r_tx <= w_tx_next;
      if (w_accept) begin
        r_shift    <= tx_i;
        r_parity   <= uart_parity(MaxDataBits'(tx_i), ParityOdd);
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (w_bit_last) begin
        if (r_state == e_data) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 1'b1;
        end
        if (r_state == e_stop) begin
          r_stop_idx <= r_stop_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (8N1, 8E1, 8O1, 5N2) at 4 clocks
// per bit, checked cycle by cycle against a frame model built from the framing rules.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int Cpb = 4;

  logic       clk    = 1'b0;
  logic       rstN   = 1'b1;
  logic [3:0] rValid = '0;
  logic [8:0] rData [4];
  wire  [3:0] wTx;
  wire  [3:0] wRdy;
  wire  [3:0] wDone;

  int checks = 0;
  int errors = 0;

  int cfgData [4] = '{8, 8, 8, 5};
  int cfgPar  [4] = '{0, 1, 1, 0};
  int cfgOdd  [4] = '{0, 0, 1, 0};
  int cfgStop [4] = '{1, 1, 1, 2};

  logic expBits[$];

`ifdef UART_TX_CTS_EN
  logic rCtsN = 1'b0;
  localparam logic RdyInReset = 1'b0;
`else
  localparam logic RdyInReset = 1'b1;
`endif

  always #5 clk = ~clk;

  uart_tx #(.clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bits_p(0), .parity_odd_p(0), .stop_bits_p(1)) dut8n1 (
    .clk_i(clk), .reset_n_i(rstN), .tx_v_i(rValid[0]), .tx_i(rData[0][7:0]),
    .tx_ready_o(wRdy[0]), .tx_o(wTx[0]), .tx_done_o(wDone[0])
`ifdef UART_TX_CTS_EN
    , .cts_n_i(rCtsN)
`endif
  );

  uart_tx #(.clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bits_p(1), .parity_odd_p(0), .stop_bits_p(1)) dut8e1 (
    .clk_i(clk), .reset_n_i(rstN), .tx_v_i(rValid[1]), .tx_i(rData[1][7:0]),
    .tx_ready_o(wRdy[1]), .tx_o(wTx[1]), .tx_done_o(wDone[1])
`ifdef UART_TX_CTS_EN
    , .cts_n_i(1'b0)
`endif
  );

  uart_tx #(.clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bits_p(1), .parity_odd_p(1), .stop_bits_p(1)) dut8o1 (
    .clk_i(clk), .reset_n_i(rstN), .tx_v_i(rValid[2]), .tx_i(rData[2][7:0]),
    .tx_ready_o(wRdy[2]), .tx_o(wTx[2]), .tx_done_o(wDone[2])
`ifdef UART_TX_CTS_EN
    , .cts_n_i(1'b0)
`endif
  );

  uart_tx #(.clk_per_bit_p(Cpb), .data_bits_p(5), .parity_bits_p(0), .parity_odd_p(0), .stop_bits_p(2)) dut5n2 (
    .clk_i(clk), .reset_n_i(rstN), .tx_v_i(rValid[3]), .tx_i(rData[3][4:0]),
    .tx_ready_o(wRdy[3]), .tx_o(wTx[3]), .tx_done_o(wDone[3])
`ifdef UART_TX_CTS_EN
    , .cts_n_i(1'b0)
`endif
  );

  // Reference frame as a list of bit levels: start, data LSB first, parity, stops.
  function automatic void model_frame(input int k, input logic [8:0] word);
    int ones;
    ones = 0;
    expBits.delete();
    expBits.push_back(1'b0);
    for (int i = 0; i < cfgData[k]; i++) begin
      expBits.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (cfgPar[k] != 0) expBits.push_back(((ones + cfgOdd[k]) % 2) == 1);
    for (int i = 0; i < cfgStop[k]; i++) expBits.push_back(1'b1);
  endfunction

  task automatic test_reset();
    #2 rstN = 1'b0;
    rValid = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (wTx[k] !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx dut%0d: got %b want 1", k, wTx[k]); end
      checks++; if (wRdy[k] !== RdyInReset) begin errors++; $display("[TB] FAIL reset_ready dut%0d: got %b want %b", k, wRdy[k], RdyInReset); end
      checks++; if (wDone[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done dut%0d: got %b want 0", k, wDone[k]); end
    end
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (wRdy[k] !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready dut%0d: got %b want 1", k, wRdy[k]); end
      checks++; if (wTx[k] !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_tx dut%0d: got %b want 1", k, wTx[k]); end
    end
  endtask

  task automatic test_frames();
    logic [8:0] words[$];
    int len;
    logic expTx;
    for (int k = 0; k < 4; k++) begin
      words.delete();
      case (k)
        0:       words.push_back(9'h055);
        1:       begin words.push_back(9'h007); words.push_back(9'h055); end
        2:       words.push_back(9'h007);
        default: words.push_back(9'h01F);
      endcase
      for (int r = 0; r < 6; r++) words.push_back(9'($urandom_range(0, 511)));
      foreach (words[w]) begin
        @(negedge clk);
        rValid[k] = 1'b1;
        rData[k]  = words[w];
        checks++; if (wRdy[k] !== 1'b1) begin errors++; $display("[TB] FAIL accept_ready dut%0d: got %b want 1", k, wRdy[k]); end
        model_frame(k, words[w]);
        len = expBits.size() * Cpb;
        for (int c = 1; c <= len + 1; c++) begin
          @(negedge clk);
          if (c == 1) rValid[k] = 1'b0;
          expTx = (c <= len) ? expBits[(c - 1) / Cpb] : 1'b1;
          checks++; if (wTx[k] !== expTx) begin errors++; $display("[TB] FAIL frame_tx dut%0d word %h cycle %0d: got %b want %b", k, words[w], c, wTx[k], expTx); end
          checks++; if (wDone[k] !== (c == len)) begin errors++; $display("[TB] FAIL frame_done dut%0d word %h cycle %0d: got %b want %b", k, words[w], c, wDone[k], (c == len)); end
          checks++; if (wRdy[k] !== (c == len + 1)) begin errors++; $display("[TB] FAIL frame_ready dut%0d word %h cycle %0d: got %b want %b", k, words[w], c, wRdy[k], (c == len + 1)); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic expWave[$];
    logic line[$];
    logic [7:0] got[$];
    int framingErr;
    int i;
    logic [7:0] b;
    expWave.delete();
    model_frame(0, 9'h0A5);
    foreach (expBits[j]) repeat (Cpb) expWave.push_back(expBits[j]);
    expWave.push_back(1'b1);
    model_frame(0, 9'h03C);
    foreach (expBits[j]) repeat (Cpb) expWave.push_back(expBits[j]);
    expWave.push_back(1'b1);
    @(negedge clk);
    rValid[0] = 1'b1;
    rData[0]  = 9'h0A5;
    for (int c = 1; c <= expWave.size(); c++) begin
      @(negedge clk);
      if (c == 1)  rData[0]  = 9'h03C;
      if (c == 42) rValid[0] = 1'b0;
      line.push_back(wTx[0]);
      checks++; if (wTx[0] !== expWave[c-1]) begin errors++; $display("[TB] FAIL b2b_tx cycle %0d: got %b want %b", c, wTx[0], expWave[c-1]); end
      checks++; if (wDone[0] !== (c == 40 || c == 81)) begin errors++; $display("[TB] FAIL b2b_done cycle %0d: got %b want %b", c, wDone[0], (c == 40 || c == 81)); end
      checks++; if (wRdy[0] !== (c == 41 || c == 82)) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d: got %b want %b", c, wRdy[0], (c == 41 || c == 82)); end
    end
    // Loopback through a mid-bit sampling receiver model.
    framingErr = 0;
    i = 0;
    while (i + 10 * Cpb <= line.size()) begin
      if (line[i] == 1'b0) begin
        if (line[i + Cpb/2] !== 1'b0) framingErr++;
        for (int j = 0; j < 8; j++) b[j] = line[i + (1 + j) * Cpb + Cpb/2];
        if (line[i + 9 * Cpb + Cpb/2] !== 1'b1) framingErr++;
        got.push_back(b);
        i += 10 * Cpb;
      end else begin
        i++;
      end
    end
    checks++; if (got.size() != 2) begin errors++; $display("[TB] FAIL loopback_count: got %0d want 2", got.size()); end
    checks++; if (framingErr != 0) begin errors++; $display("[TB] FAIL loopback_framing: got %0d errors want 0", framingErr); end
    if (got.size() >= 2) begin
      checks++; if (got[0] !== 8'hA5) begin errors++; $display("[TB] FAIL loopback_word0: got %h want a5", got[0]); end
      checks++; if (got[1] !== 8'h3C) begin errors++; $display("[TB] FAIL loopback_word1: got %h want 3c", got[1]); end
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    rValid[0] = 1'b1;
    rData[0]  = 9'h000;
    @(negedge clk);
    rValid[0] = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (wTx[0] !== 1'b0) begin errors++; $display("[TB] FAIL midframe_pre_tx: got %b want 0", wTx[0]); end
    #1 rstN = 1'b0;
    #1;
    checks++; if (wTx[0] !== 1'b1) begin errors++; $display("[TB] FAIL midframe_reset_tx: got %b want 1", wTx[0]); end
    checks++; if (wDone[0] !== 1'b0) begin errors++; $display("[TB] FAIL midframe_reset_done: got %b want 0", wDone[0]); end
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      checks++; if (wDone[0] !== 1'b0) begin errors++; $display("[TB] FAIL midframe_done cycle %0d: got %b want 0", c, wDone[0]); end
      checks++; if (wTx[0] !== 1'b1) begin errors++; $display("[TB] FAIL midframe_tx cycle %0d: got %b want 1", c, wTx[0]); end
    end
    checks++; if (wRdy[0] !== 1'b1) begin errors++; $display("[TB] FAIL midframe_ready: got %b want 1", wRdy[0]); end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int waitCycles;
    int len;
    @(negedge clk);
    rCtsN = 1'b1;
    repeat (3) @(negedge clk);
    rValid[0] = 1'b1;
    rData[0]  = 9'h0C3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (wRdy[0] !== 1'b0) begin errors++; $display("[TB] FAIL cts_blocked_ready cycle %0d: got %b want 0", c, wRdy[0]); end
      checks++; if (wTx[0] !== 1'b1) begin errors++; $display("[TB] FAIL cts_blocked_tx cycle %0d: got %b want 1", c, wTx[0]); end
    end
    rCtsN = 1'b0;
    waitCycles = 0;
    while (wRdy[0] !== 1'b1 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++; if (waitCycles < 2 || waitCycles > 3) begin errors++; $display("[TB] FAIL cts_latency: got %0d cycles want 2..3", waitCycles); end
    model_frame(0, 9'h0C3);
    len = expBits.size() * Cpb;
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c == 1) rValid[0] = 1'b0;
      if (c == 5) rCtsN = 1'b1;
      checks++; if (wTx[0] !== ((c <= len) ? expBits[(c - 1) / Cpb] : 1'b1)) begin errors++; $display("[TB] FAIL cts_frame_tx cycle %0d: got %b", c, wTx[0]); end
      checks++; if (wDone[0] !== (c == len)) begin errors++; $display("[TB] FAIL cts_frame_done cycle %0d: got %b want %b", c, wDone[0], (c == len)); end
      checks++; if (wRdy[0] !== 1'b0) begin errors++; $display("[TB] FAIL cts_frame_ready cycle %0d: got %b want 0", c, wRdy[0]); end
    end
    rCtsN = 1'b0;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    for (int k = 0; k < 4; k++) rData[k] = '0;
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
